// File: rtl/fetch_pkg.sv
// Shared types and address defaults for the fetch front-end.
// Counters are CNT_W bits wide, enough for up to 7 outstanding fetches.
package fetch_pkg;
  localparam logic [31:0] DEF_RESET_ADDR = 32'hbfc0_0000;
  localparam logic [31:0] DEF_EXC_ADDR   = 32'hbfc0_0380;
  localparam int unsigned CNT_W          = 3;

  typedef enum logic [2:0] {NONE, ERET, EXC, MISP, PRED} redir_src_t;
  typedef enum logic [1:0] {RUN, HOLD, SLOT} fetch_state_t;
endpackage

// File: rtl/fetch_inflight_tracker.sv
// Counts accepted-but-unreturned fetches and wrong-path beats still to drop.
// Discard is combinational from inst_data_ok; counters update on the clock edge.
module fetch_inflight_tracker
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic acc,
  input  logic inst_data_ok,
  input  logic flush,
  input  logic hold_acc,
  output logic can_req,
  output logic inst_discard
);
  logic [CNT_W-1:0] out_cnt, out_cnt_n;
  logic [CNT_W-1:0] cancel_cnt, cancel_cnt_n;

  assign out_cnt_n    = out_cnt + CNT_W'(acc) - CNT_W'(inst_data_ok);
  assign inst_discard = inst_data_ok && (cancel_cnt != '0);
  assign can_req      = out_cnt < CNT_W'(MAX_OUTSTANDING);

  // A redirect makes everything still in flight (including this cycle's accept) wrong-path.
  always_comb begin
    cancel_cnt_n = cancel_cnt - CNT_W'(inst_discard) + CNT_W'(hold_acc);
    if (flush) cancel_cnt_n = out_cnt_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt    <= '0;
      cancel_cnt <= '0;
    end else begin
      out_cnt    <= out_cnt_n;
      cancel_cnt <= cancel_cnt_n;
    end
  end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer with fixed-priority redirects; targets appear one cycle after redirect/accept.
// Holds inst_addr stable until inst_addr_ok; FETCH_BRANCH_PREDICT_EN enables predicted-taken SLOT handling.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = DEF_RESET_ADDR,
  parameter logic [31:0] EXC_ADDR        = DEF_EXC_ADDR,
  parameter int unsigned MAX_OUTSTANDING = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        exc_i,
  input  logic        mispredict_i,
  input  logic [31:0] real_target_i,
  input  logic        bp_take_i,
  input  logic [31:0] bp_target_i,
  input  logic        stall_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        inst_discard
);
  fetch_state_t state, state_n;
  redir_src_t   src;
  logic [31:0]  pc, pc_n, tgt, tgt_n, src_tgt;
  logic         req_held, can_req, acc, pend, flush, hold_acc, pred_take;

`ifdef FETCH_BRANCH_PREDICT_EN
  assign pred_take = bp_take_i && (state == RUN);
`else
  logic unused_bp;
  assign unused_bp = bp_take_i;
  assign pred_take = 1'b0;
`endif

  assign inst_req  = !reset && can_req && (!stall_i || req_held);
  assign inst_addr = pc;
  assign acc       = inst_req && inst_addr_ok;
  assign pend      = inst_req && !inst_addr_ok;
  assign flush     = (src == ERET) || (src == EXC) || (src == MISP);
  assign hold_acc  = (state == HOLD) && acc;

  always_comb begin
    src     = NONE;
    src_tgt = '0;
    if (eret_i) begin
      src     = ERET;
      src_tgt = epc_i;
    end else if (exc_i) begin
      src     = EXC;
      src_tgt = EXC_ADDR;
    end else if (mispredict_i) begin
      src     = MISP;
      src_tgt = real_target_i;
    end else if (pred_take) begin
      src     = PRED;
      src_tgt = bp_target_i;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    case (state)
      RUN, SLOT: begin
        if (flush) begin
          if (pend) begin
            tgt_n   = src_tgt;
            state_n = HOLD;
          end else begin
            pc_n    = src_tgt;
            state_n = RUN;
          end
        end else if (state == SLOT) begin
          // The accept here is the delay slot; it is kept and the branch target follows.
          if (acc) begin
            pc_n    = tgt;
            state_n = RUN;
          end
        end else begin
          if (acc) pc_n = pc + 32'd4;
          if (src == PRED) begin
            tgt_n   = src_tgt;
            state_n = SLOT;
          end
        end
      end
      HOLD: begin
        if (flush) tgt_n = src_tgt;
        if (acc) begin
          pc_n    = flush ? src_tgt : tgt;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_ADDR;
      tgt      <= RESET_ADDR;
      req_held <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      tgt      <= tgt_n;
      req_held <= pend;
    end
  end

  fetch_inflight_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_trk (
    .clk         (clk),
    .reset       (reset),
    .acc         (acc),
    .inst_data_ok(inst_data_ok),
    .flush       (flush),
    .hold_acc    (hold_acc),
    .can_req     (can_req),
    .inst_discard(inst_discard)
  );
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomized and directed bench for fetch_redirect_ctrl against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_redirect_ctrl;
  localparam int          MAX_OUT = 3;
  localparam logic [31:0] RST_A   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_A   = 32'hbfc0_0380;
`ifdef FETCH_BRANCH_PREDICT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        eret_i = 1'b0, exc_i = 1'b0, mispredict_i = 1'b0, bp_take_i = 1'b0, stall_i = 1'b0;
  logic [31:0] epc_i = '0, real_target_i = '0, bp_target_i = '0;
  logic        inst_req, inst_addr_ok = 1'b0, inst_data_ok = 1'b0, inst_discard;
  logic [31:0] inst_addr;

  fetch_redirect_ctrl #(.RESET_ADDR(RST_A), .EXC_ADDR(EXC_A), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .eret_i(eret_i), .epc_i(epc_i), .exc_i(exc_i),
    .mispredict_i(mispredict_i), .real_target_i(real_target_i), .bp_take_i(bp_take_i),
    .bp_target_i(bp_target_i), .stall_i(stall_i), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_discard(inst_discard)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: fetch PC, pending redirect/slot target, and one drop flag per in-flight beat.
  logic [31:0] m_pc = RST_A;
  logic [31:0] m_tgt = RST_A;
  bit          m_hold_pend = 1'b0, m_slot_pend = 1'b0, m_held = 1'b0;
  bit          m_q[$];
  bit          obs_req, obs_disc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit st, input bit er, input logic [31:0] ep, input bit ex,
                      input bit mp, input logic [31:0] rt, input bit bp, input logic [31:0] bt,
                      input bit aok, input bit dok);
    bit mreq, acc, dk, have, pred, exp_disc;
    logic [31:0] tg;
    @(negedge clk);
    dk = dok && (m_q.size() != 0);
    stall_i = st; eret_i = er; epc_i = ep; exc_i = ex; mispredict_i = mp;
    real_target_i = rt; bp_take_i = bp; bp_target_i = bt;
    inst_addr_ok = aok; inst_data_ok = dk;
    #1;
    mreq     = (m_q.size() < MAX_OUT) && (!st || m_held);
    exp_disc = dk ? m_q[0] : 1'b0;
    obs_req  = inst_req;
    obs_disc = inst_discard;
    check_val("inst_req", 32'(inst_req), 32'(mreq));
    check_val("inst_addr", inst_addr, m_pc);
    check_val("inst_discard", 32'(inst_discard), 32'(exp_disc));

    acc = mreq && aok;
    have = 1'b0; pred = 1'b0; tg = '0;
    if (er) begin have = 1'b1; tg = ep; end
    else if (ex) begin have = 1'b1; tg = EXC_A; end
    else if (mp) begin have = 1'b1; tg = rt; end
    else if (BP_EN && bp) begin pred = 1'b1; tg = bt; end

    if (dk) void'(m_q.pop_front());
    if (acc) m_q.push_back(m_hold_pend);
    if (have) foreach (m_q[i]) m_q[i] = 1'b1;

    if (m_hold_pend) begin
      if (have) m_tgt = tg;
      if (acc) begin m_pc = m_tgt; m_hold_pend = 1'b0; end
    end else if (have) begin
      m_slot_pend = 1'b0;
      if (mreq && !aok) begin m_tgt = tg; m_hold_pend = 1'b1; end
      else m_pc = tg;
    end else if (m_slot_pend) begin
      if (acc) begin m_pc = m_tgt; m_slot_pend = 1'b0; end
    end else begin
      if (acc) m_pc = m_pc + 32'd4;
      if (pred) begin m_tgt = tg; m_slot_pend = 1'b1; end
    end
    m_held = mreq && !aok;
  endtask

  task automatic idle(input bit st, input bit aok, input bit dok);
    step(st, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, aok, dok);
  endtask

  task automatic expect_addr(input string tag, input logic [31:0] exp);
    @(posedge clk);
    #1;
    check_val(tag, inst_addr, exp);
  endtask

  // Reset is asserted away from any clock edge so its asynchronous effect is visible at once.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall_i = 1'b0; eret_i = 1'b0; exc_i = 1'b0; mispredict_i = 1'b0; bp_take_i = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #1;
    check_val("rst_req", 32'(inst_req), 32'd0);
    check_val("rst_addr", inst_addr, RST_A);
    check_val("rst_disc", 32'(inst_discard), 32'd0);
    check_val("rst_out_cnt", 32'(dut.u_trk.out_cnt), 32'd0);
    check_val("rst_cancel_cnt", 32'(dut.u_trk.cancel_cnt), 32'd0);
    m_pc = RST_A; m_tgt = RST_A;
    m_hold_pend = 1'b0; m_slot_pend = 1'b0; m_held = 1'b0;
    m_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit er, ex, mp, bp;
    int r;

    // Sequential fetch straight out of reset.
    do_reset();
    idle(1'b0, 1'b1, 1'b0);
    expect_addr("seq_addr1", 32'hbfc0_0004);
    idle(1'b0, 1'b1, 1'b0);
    expect_addr("seq_addr2", 32'hbfc0_0008);
    idle(1'b0, 1'b0, 1'b1);
    check_val("seq_disc", 32'(obs_disc), 32'd0);

    // Mispredict with two beats in flight and no request pending.
    do_reset();
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, '0, 1'b0, 1'b0);
    expect_addr("misp_addr", 32'h8000_1000);
    idle(1'b0, 1'b1, 1'b1);
    check_val("misp_disc1", 32'(obs_disc), 32'd1);
    idle(1'b0, 1'b0, 1'b1);
    check_val("misp_disc2", 32'(obs_disc), 32'd1);
    idle(1'b0, 1'b0, 1'b1);
    check_val("misp_disc3", 32'(obs_disc), 32'd0);

    // Exception while a request waits for acceptance at 0xbfc00010.
    do_reset();
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    expect_addr("hold_addr1", 32'hbfc0_0010);
    idle(1'b0, 1'b0, 1'b0);
    expect_addr("hold_addr2", 32'hbfc0_0010);
    idle(1'b0, 1'b1, 1'b0);
    expect_addr("hold_exc_addr", EXC_A);
    idle(1'b0, 1'b0, 1'b1);
    check_val("hold_disc_0c", 32'(obs_disc), 32'd1);
    idle(1'b0, 1'b0, 1'b1);
    check_val("hold_disc_10", 32'(obs_disc), 32'd1);

`ifdef FETCH_BRANCH_PREDICT_EN
    // Predicted-taken branch: delay slot at 0x80000008 is kept, then the target.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
    expect_addr("slot_addr", 32'h8000_0008);
    idle(1'b0, 1'b1, 1'b1);
    expect_addr("slot_tgt", 32'h8000_0040);
    idle(1'b0, 1'b0, 1'b1);
    check_val("slot_keep", 32'(obs_disc), 32'd0);
`endif

    // eret beats exc in the same cycle.
    do_reset();
    step(1'b1, 1'b1, 32'h8000_0100, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    expect_addr("prio_addr", 32'h8000_0100);

    // Outstanding limit reached while stalled.
    do_reset();
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    check_val("full_req", 32'(obs_req), 32'd0);

    // Reset asserted while in HOLD.
    do_reset();
    idle(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    expect_addr("pre_rst_hold", 32'hbfc0_0004);
    do_reset();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(599) == 0) do_reset();
      r  = $urandom_range(19);
      er = (r == 0) || (r == 5);
      ex = (r == 1) || (r == 5) || (r == 6);
      mp = (r == 2) || (r == 6);
      bp = (r == 3) || (r == 4) || (r == 6);
      step($urandom_range(4) == 0, er, $urandom() & 32'hffff_fffc, ex, mp,
           $urandom() & 32'hffff_fffc, bp, $urandom() & 32'hffff_fffc,
           $urandom_range(9) < 6, $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
